// File: rtl/mem_burst_fsm.sv
// Multi-beat memory access sequencer: IDLE->ACTIVE handshake, then a burst of
// write or read strobes with optional wait states, address wrap and cs-drop abort.
module mem_burst_fsm #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned LEN_W    = 4,
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [LEN_W-1:0]  len_in,
    output logic              wr_enb,
    output logic              rd_enb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned WAIT_W    = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam int unsigned WAIT_LOAD = (WAIT_CYC > 0) ? WAIT_CYC - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_WRITE,
        S_READ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   addr_nx;
    logic [LEN_W-1:0]    beats_q, beats_nx;
    logic [WAIT_W-1:0]   wait_q, wait_nx;
    logic                dir_wr_q, dir_wr_nx;
    logic                err_nx;

    // State, datapath and registered Moore outputs (decoded from the next state)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            mem_addr <= '0;
            beats_q  <= '0;
            wait_q   <= '0;
            dir_wr_q <= 1'b0;
            wr_enb   <= 1'b0;
            rd_enb   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            mem_addr <= addr_nx;
            beats_q  <= beats_nx;
            wait_q   <= wait_nx;
            dir_wr_q <= dir_wr_nx;
            wr_enb   <= (state_nx == S_WRITE);
            rd_enb   <= (state_nx == S_READ);
            busy     <= (state_nx != S_IDLE);
            done     <= (state_nx == S_DONE);
            err      <= err_nx;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nx  = state;
        addr_nx   = mem_addr;
        beats_nx  = beats_q;
        wait_nx   = wait_q;
        dir_wr_nx = dir_wr_q;
        err_nx    = 1'b0;

        case (state)
            S_IDLE: begin
                if (cs && !wr_en && !rd_en) begin
                    state_nx = S_ACTIVE;
                end
            end

            S_ACTIVE: begin
                if (cs && wr_en) begin
                    state_nx  = S_WRITE;
                    addr_nx   = addr_in;
                    beats_nx  = len_in;
                    dir_wr_nx = 1'b1;
                end else if (cs && rd_en) begin
                    state_nx  = S_READ;
                    addr_nx   = addr_in;
                    beats_nx  = len_in;
                    dir_wr_nx = 1'b0;
                end else begin
                    state_nx = S_IDLE;
                end
            end

            S_WRITE, S_READ: begin
                if (!cs) begin
                    state_nx = S_IDLE;
                    beats_nx = '0;
                    err_nx   = 1'b1;
                end else if (beats_q == '0) begin
                    state_nx = S_DONE;
                end else if (WAIT_CYC == 0) begin
                    addr_nx  = ADDR_W'(mem_addr + 1'b1);
                    beats_nx = LEN_W'(beats_q - 1'b1);
                end else begin
                    state_nx = S_WAIT;
                    wait_nx  = WAIT_W'(WAIT_LOAD);
                end
            end

            S_WAIT: begin
                if (!cs) begin
                    state_nx = S_IDLE;
                    beats_nx = '0;
                    err_nx   = 1'b1;
                end else if (wait_q == '0) begin
                    state_nx = dir_wr_q ? S_WRITE : S_READ;
                    addr_nx  = ADDR_W'(mem_addr + 1'b1);
                    beats_nx = LEN_W'(beats_q - 1'b1);
                end else begin
                    wait_nx = WAIT_W'(wait_q - 1'b1);
                end
            end

            S_DONE: begin
                state_nx = S_IDLE;
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_burst_fsm.sv
// Self-checking bench for mem_burst_fsm: one instance with WAIT_CYC=0, one with
// WAIT_CYC=1, each compared cycle by cycle against a per-burst expected timeline.
module tb_mem_burst_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs      [2];
    logic       wr_en   [2];
    logic       rd_en   [2];
    logic [7:0] addr_in [2];
    logic [3:0] len_in  [2];
    logic       wr_enb  [2];
    logic       rd_enb  [2];
    logic       busy    [2];
    logic       done    [2];
    logic       err     [2];
    logic [7:0] mem_addr[2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_burst_fsm #(.ADDR_W(8), .LEN_W(4), .WAIT_CYC(0)) u_w0 (
        .clk(clk), .reset(reset), .cs(cs[0]), .wr_en(wr_en[0]), .rd_en(rd_en[0]),
        .addr_in(addr_in[0]), .len_in(len_in[0]), .wr_enb(wr_enb[0]), .rd_enb(rd_enb[0]),
        .mem_addr(mem_addr[0]), .busy(busy[0]), .done(done[0]), .err(err[0])
    );

    mem_burst_fsm #(.ADDR_W(8), .LEN_W(4), .WAIT_CYC(1)) u_w1 (
        .clk(clk), .reset(reset), .cs(cs[1]), .wr_en(wr_en[1]), .rd_en(rd_en[1]),
        .addr_in(addr_in[1]), .len_in(len_in[1]), .wr_enb(wr_enb[1]), .rd_enb(rd_enb[1]),
        .mem_addr(mem_addr[1]), .busy(busy[1]), .done(done[1]), .err(err[1])
    );

    // One expected cycle of the burst timeline, plus the cs value to drive afterwards
    typedef struct {
        logic       wr;
        logic       rd;
        logic       busy;
        logic       done;
        logic       err;
        logic       chk_addr;
        logic       cs_nx;
        logic [7:0] addr;
    } step_t;

    step_t q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic step_t mk(logic w, logic r, logic b, logic d, logic e,
                                 logic ca, logic [7:0] a, logic c);
        step_t s;
        s.wr = w; s.rd = r; s.busy = b; s.done = d; s.err = e;
        s.chk_addr = ca; s.addr = a; s.cs_nx = c;
        return s;
    endfunction

    // Timeline: each beat is a strobe cycle, then w wait cycles (not after the last),
    // then one DONE cycle and IDLE. An abort truncates after cycle abort_at.
    task automatic build(input int w, input bit is_wr, input logic [7:0] a,
                         input int len, input int abort_at);
        step_t last;
        q.delete();
        for (int b = 0; b <= len; b++) begin
            q.push_back(mk(is_wr, !is_wr, 1, 0, 0, 1, 8'(a + 8'(b)), 1));
            if (b < len)
                for (int j = 0; j < w; j++)
                    q.push_back(mk(0, 0, 1, 0, 0, 1, 8'(a + 8'(b)), 1));
        end
        q.push_back(mk(0, 0, 1, 1, 0, 0, 8'h00, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 0));
        if (abort_at >= 0) begin
            while (q.size() > abort_at + 1) void'(q.pop_back());
            q[abort_at].cs_nx = 1'b0;
            last = q[abort_at];
            q.push_back(mk(0, 0, 0, 0, 1, 1, last.addr, 0));
            q.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 0));
        end
    endtask

    task automatic check_outs(input string tag, input int k, input step_t s);
        check({tag, ".wr_enb"}, 32'(wr_enb[k]), 32'(s.wr));
        check({tag, ".rd_enb"}, 32'(rd_enb[k]), 32'(s.rd));
        check({tag, ".busy"},   32'(busy[k]),   32'(s.busy));
        check({tag, ".done"},   32'(done[k]),   32'(s.done));
        check({tag, ".err"},    32'(err[k]),    32'(s.err));
        if (s.chk_addr) check({tag, ".mem_addr"}, 32'(mem_addr[k]), 32'(s.addr));
    endtask

    // Full transaction: cs alone, command in ACTIVE, then the burst timeline
    task automatic run(input string name, input int k, input bit is_wr, input bit both,
                       input logic [7:0] a, input int len, input int abort_at, input int rst_at);
        build((k == 0) ? 0 : 1, is_wr, a, len, abort_at);
        @(negedge clk);
        check_outs({name, ".idle"}, k, mk(0, 0, 0, 0, 0, 0, 8'h00, 0));
        cs[k] = 1'b1; wr_en[k] = 1'b0; rd_en[k] = 1'b0;
        @(negedge clk);
        check_outs({name, ".active"}, k, mk(0, 0, 1, 0, 0, 0, 8'h00, 0));
        wr_en[k]   = is_wr | both;
        rd_en[k]   = !is_wr | both;
        addr_in[k] = a;
        len_in[k]  = 4'(len);
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            check_outs($sformatf("%s.c%0d", name, i), k, q[i]);
            if (i == rst_at) begin
                #2 reset = 1'b1;
                #1;
                check_outs({name, ".in_reset"}, k, mk(0, 0, 0, 0, 0, 1, 8'h00, 0));
                @(negedge clk);
                reset = 1'b0;
                cs[k] = 1'b0; wr_en[k] = 1'b0; rd_en[k] = 1'b0;
                return;
            end
            cs[k]      = q[i].cs_nx;
            wr_en[k]   = q[i].cs_nx ? 1'($urandom % 2) : 1'b0;
            rd_en[k]   = q[i].cs_nx ? 1'($urandom % 2) : 1'b0;
            addr_in[k] = 8'($urandom);
            len_in[k]  = 4'($urandom);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            cs[k] = 1'b0; wr_en[k] = 1'b0; rd_en[k] = 1'b0;
            addr_in[k] = 8'h00; len_in[k] = 4'h0;
        end
        reset = 1'b1;
        #12;
        for (int k = 0; k < 2; k++)
            check_outs($sformatf("reset%0d", k), k, mk(0, 0, 0, 0, 0, 1, 8'h00, 0));
        @(negedge clk);
        reset = 1'b0;

        run("t1_write4",  1, 1, 0, 8'h10, 3, -1, -1);
        run("t2_readwrap", 0, 0, 0, 8'hFE, 2, -1, -1);
        run("t3_both_w1", 1, 1, 1, 8'h42, 0, -1, -1);
        run("t3_both_w0", 0, 1, 1, 8'h77, 0, -1, -1);
        run("t4_abort",   1, 0, 0, 8'h20, 7, 5, -1);

        // Command straight from IDLE is ignored; ACTIVE with no command falls back silently
        @(negedge clk);
        check_outs("t5.idle", 1, mk(0, 0, 0, 0, 0, 0, 8'h00, 0));
        cs[1] = 1'b1; wr_en[1] = 1'b1;
        @(negedge clk);
        check_outs("t5.cmd_from_idle", 1, mk(0, 0, 0, 0, 0, 0, 8'h00, 0));
        wr_en[1] = 1'b0;
        @(negedge clk);
        check_outs("t5.active", 1, mk(0, 0, 1, 0, 0, 0, 8'h00, 0));
        @(negedge clk);
        check_outs("t5.no_cmd", 1, mk(0, 0, 0, 0, 0, 0, 8'h00, 0));
        cs[1] = 1'b0;

        run("t6_reset",  1, 1, 0, 8'h30, 5, -1, 2);
        run("t6_after",  1, 1, 0, 8'h50, 1, -1, -1);

        for (int n = 0; n < 30; n++) begin
            int  k, len, nsteps, ab;
            bit  wr, both;
            k      = int'($urandom % 2);
            both   = ($urandom % 4) == 0;
            wr     = both ? 1'b1 : 1'($urandom % 2);
            len    = int'($urandom % 16);
            nsteps = (len + 1) + len * k;
            ab     = (($urandom % 4) == 0) ? int'($urandom % 32'(nsteps)) : -1;
            run($sformatf("rnd%0d", n), k, wr, both, 8'($urandom), len, ab, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
